// File: rtl/decoder_mac_scheduler_if.sv
// Operand/result bundle for decoder_mac_scheduler: valid/ready input bundle and held valid/ready result bundle.
// Handshake: a transfer happens on a rising edge where valid && ready; the producer holds valid and data stable until then.
interface decoder_mac_scheduler_if #(
  parameter int N_input  = 2,
  parameter int M_output = 9,
  parameter int BITSIZE  = 32
);
  logic                                  in_valid;
  logic                                  in_ready;
  logic [N_input*BITSIZE-1:0]            z;
  logic [N_input*M_output*BITSIZE-1:0]   w;
  logic [M_output*BITSIZE-1:0]           b;
  logic                                  out_valid;
  logic                                  out_ready;
  logic [M_output*BITSIZE-1:0]           out;

  modport master (
    output in_valid, z, w, b, out_ready,
    input  in_ready, out_valid, out
  );

  modport slave (
    input  in_valid, z, w, b, out_ready,
    output in_ready, out_valid, out
  );
endinterface

// File: rtl/decoder_mac_scheduler.sv
// Time-multiplexed decoder layer: out[j] = b[j] + sum_i z[i]*w[j*N_input+i] in signed Q16.16,
// one shared multiply and one shared add, one MAC per cycle walking (j, i).
module decoder_mac_scheduler #(
  parameter int N_input  = 2,
  parameter int M_output = 9,
  parameter int BITSIZE  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  decoder_mac_scheduler_if.slave bus,
  output logic                  busy,
  output logic [1:0]            dbg_state
);
  localparam int IW   = $clog2((N_input  > 2) ? N_input  : 2);
  localparam int JW   = $clog2((M_output > 2) ? M_output : 2);
  localparam int FRAC = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [N_input*BITSIZE-1:0]          z_reg;
  logic [N_input*M_output*BITSIZE-1:0] w_reg;
  logic [M_output*BITSIZE-1:0]         b_reg;
  logic [M_output*BITSIZE-1:0]         out_reg;
  logic [BITSIZE-1:0]                  acc;
  logic [IW-1:0]                       i_cnt;
  logic [JW-1:0]                       j_cnt;

  logic                                last_i, last_j;
  logic [BITSIZE-1:0]                  z_sel, w_sel, b_next, mul, acc_next;
  logic signed [2*BITSIZE-1:0]         prod;
  logic                                unused_prod_bits;

  assign last_i = (i_cnt == IW'(N_input - 1));
  assign last_j = (j_cnt == JW'(M_output - 1));

  // Shared MAC: full-width signed product, arithmetic >>16, keep low word (floor, wraps).
  always_comb begin
    z_sel    = z_reg[int'(i_cnt)*BITSIZE +: BITSIZE];
    w_sel    = w_reg[(int'(j_cnt)*N_input + int'(i_cnt))*BITSIZE +: BITSIZE];
    b_next   = last_j ? b_reg[int'(j_cnt)*BITSIZE +: BITSIZE]
                      : b_reg[(int'(j_cnt) + 1)*BITSIZE +: BITSIZE];
    prod     = $signed({{BITSIZE{z_sel[BITSIZE-1]}}, z_sel}) *
               $signed({{BITSIZE{w_sel[BITSIZE-1]}}, w_sel});
    mul      = prod[BITSIZE+FRAC-1:FRAC];
    acc_next = acc + mul;
  end

  assign unused_prod_bits = ^{prod[2*BITSIZE-1:BITSIZE+FRAC], prod[FRAC-1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    busy          = 1'b0;
    case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_d = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_i && last_j) state_d = DONE;
      end
      DONE: begin
        busy          = 1'b1;
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operands are captured once per accept; out_reg slots change only while running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_reg   <= '0;
      w_reg   <= '0;
      b_reg   <= '0;
      out_reg <= '0;
      acc     <= '0;
      i_cnt   <= '0;
      j_cnt   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            z_reg <= bus.z;
            w_reg <= bus.w;
            b_reg <= bus.b;
            acc   <= bus.b[BITSIZE-1:0];
            i_cnt <= '0;
            j_cnt <= '0;
          end
        end
        RUN: begin
          if (!last_i) begin
            acc   <= acc_next;
            i_cnt <= i_cnt + IW'(1);
          end else begin
            out_reg[int'(j_cnt)*BITSIZE +: BITSIZE] <= acc_next;
            i_cnt <= '0;
            if (!last_j) begin
              j_cnt <= j_cnt + JW'(1);
              acc   <= b_next;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.out   = out_reg;
  assign dbg_state = state_q;
endmodule

// File: tb/tb_decoder_mac_scheduler.sv
// Directed bench for decoder_mac_scheduler: default 2x9 instance plus 1x1 and 4x3 parameter corners.
module tb_decoder_mac_scheduler;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];

  decoder_mac_scheduler_if #(.N_input(2), .M_output(9), .BITSIZE(W)) bus ();
  decoder_mac_scheduler_if #(.N_input(1), .M_output(1), .BITSIZE(W)) bus11 ();
  decoder_mac_scheduler_if #(.N_input(4), .M_output(3), .BITSIZE(W)) bus43 ();

  logic       busy, busy11, busy43;
  logic [1:0] dbg_state, dbg_state11, dbg_state43;

  decoder_mac_scheduler #(.N_input(2), .M_output(9), .BITSIZE(W)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy), .dbg_state(dbg_state));
  decoder_mac_scheduler #(.N_input(1), .M_output(1), .BITSIZE(W)) u_dut11 (
    .clk(clk), .rst_n(rst_n), .bus(bus11), .busy(busy11), .dbg_state(dbg_state11));
  decoder_mac_scheduler #(.N_input(4), .M_output(3), .BITSIZE(W)) u_dut43 (
    .clk(clk), .rst_n(rst_n), .bus(bus43), .busy(busy43), .dbg_state(dbg_state43));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] q_mul(input logic [W-1:0] a, input logic [W-1:0] c);
    logic signed [63:0] p;
    p = 64'($signed(a)) * 64'($signed(c));
    return p[47:16];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- default 2x9 instance helpers ----------------
  task automatic set_default(input logic [W-1:0] z0, input logic [W-1:0] z1,
                             input logic [W-1:0] w0, input logic [W-1:0] w1,
                             input logic [W-1:0] b0, input bit ramp);
    bus.z = {z1, z0};
    for (int j = 0; j < 9; j++) begin
      bus.w[(2*j)*W +: W]   = w0;
      bus.w[(2*j+1)*W +: W] = w1;
      bus.b[j*W +: W]       = b0 + (ramp ? (32'(j) << 16) : 32'd0);
    end
  endtask

  task automatic push_default(input logic [W-1:0] e0, input bit ramp);
    for (int j = 0; j < 9; j++) exp_q.push_back(e0 + (ramp ? (32'(j) << 16) : 32'd0));
  endtask

  task automatic wait_done_default(input string tag, input int lat_exp);
    int cnt;
    bit busy_ok;
    cnt = 0;
    busy_ok = 1'b1;
    while (!bus.out_valid && cnt < 100) begin
      tick();
      cnt++;
      if (!busy) busy_ok = 1'b0;
    end
    check({tag, "_latency"}, 64'(cnt), 64'(lat_exp));
    check({tag, "_busy"}, 64'(busy_ok), 64'd1);
  endtask

  task automatic compare_default(input string tag);
    for (int j = 0; j < 9; j++) begin
      check($sformatf("%s_out%0d", tag, j), 64'(bus.out[j*W +: W]), 64'(exp_q.pop_front()));
    end
  endtask

  task automatic handshake_default(input string tag);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({tag, "_hs_valid"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_hs_ready"}, 64'(bus.in_ready), 64'd1);
  endtask

  task automatic run_default(input string tag);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    check({tag, "_in_ready_low"}, 64'(bus.in_ready), 64'd0);
    wait_done_default(tag, 18);
    compare_default(tag);
    handshake_default(tag);
  endtask

  // ---------------- 1x1 and 4x3 sweeps against the arithmetic model ----------------
  task automatic sweep11(input int iter);
    logic [W-1:0] zv, wv, bv;
    int cnt;
    zv = $urandom();
    wv = $urandom();
    bv = $urandom();
    bus11.z = zv;
    bus11.w = wv;
    bus11.b = bv;
    exp_q.push_back(bv + q_mul(zv, wv));
    bus11.in_valid = 1'b1;
    tick();
    bus11.in_valid = 1'b0;
    cnt = 0;
    while (!bus11.out_valid && cnt < 50) begin
      tick();
      cnt++;
    end
    check($sformatf("s11_%0d_latency", iter), 64'(cnt), 64'd1);
    check($sformatf("s11_%0d_out", iter), 64'(bus11.out), 64'(exp_q.pop_front()));
    bus11.out_ready = 1'b1;
    tick();
    bus11.out_ready = 1'b0;
  endtask

  task automatic sweep43(input int iter);
    logic [W-1:0] zv[4];
    logic [W-1:0] acc;
    int cnt;
    for (int i = 0; i < 4; i++) begin
      zv[i] = $urandom();
      bus43.z[i*W +: W] = zv[i];
    end
    for (int k = 0; k < 12; k++) bus43.w[k*W +: W] = $urandom();
    for (int j = 0; j < 3; j++) bus43.b[j*W +: W] = $urandom();
    for (int j = 0; j < 3; j++) begin
      acc = bus43.b[j*W +: W];
      for (int i = 0; i < 4; i++) acc = acc + q_mul(zv[i], bus43.w[(j*4+i)*W +: W]);
      exp_q.push_back(acc);
    end
    bus43.in_valid = 1'b1;
    tick();
    bus43.in_valid = 1'b0;
    cnt = 0;
    while (!bus43.out_valid && cnt < 100) begin
      tick();
      cnt++;
    end
    check($sformatf("s43_%0d_latency", iter), 64'(cnt), 64'd12);
    for (int j = 0; j < 3; j++) begin
      check($sformatf("s43_%0d_out%0d", iter, j), 64'(bus43.out[j*W +: W]), 64'(exp_q.pop_front()));
    end
    bus43.out_ready = 1'b1;
    tick();
    bus43.out_ready = 1'b0;
  endtask

  logic [9*W-1:0] snap;

  initial begin
    bus.in_valid = 1'b0;   bus.out_ready = 1'b0;   bus.z = '0;   bus.w = '0;   bus.b = '0;
    bus11.in_valid = 1'b0; bus11.out_ready = 1'b0; bus11.z = '0; bus11.w = '0; bus11.b = '0;
    bus43.in_valid = 1'b0; bus43.out_ready = 1'b0; bus43.z = '0; bus43.w = '0; bus43.b = '0;

    // Reset values
    #12;
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_out", 64'(|bus.out), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic: 1.0*0.5 + 2.0*0.5 + 0.25 = 1.75
    set_default(32'h0001_0000, 32'h0002_0000, 32'h0000_8000, 32'h0000_8000, 32'h0000_4000, 1'b0);
    push_default(32'h0001_C000, 1'b0);
    run_default("basic");

    // Signed per-output: -1*1 + 3*(-1) + j = -4 + j
    set_default(32'hFFFF_0000, 32'h0003_0000, 32'h0001_0000, 32'hFFFF_0000, 32'h0000_0000, 1'b1);
    push_default(32'hFFFC_0000, 1'b1);
    run_default("signed");

    // Truncation toward -inf: 1ulp*0.5 -> 0, -1ulp*0.5 -> -1ulp
    set_default(32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_8000, 32'h0000_8000, 32'h0000_0000, 1'b0);
    push_default(32'hFFFF_FFFF, 1'b0);
    run_default("trunc");

    // Wrap: 0x7FFF0000 + 1.0 wraps to 0x80000000
    set_default(32'h0001_0000, 32'h0000_0000, 32'h0001_0000, 32'h0001_0000, 32'h7FFF_0000, 1'b0);
    push_default(32'h8000_0000, 1'b0);
    run_default("wrap");

    // Backpressure: bundle A accepted, bundle B held on in_valid must wait for A's handshake
    set_default(32'h0001_0000, 32'h0002_0000, 32'h0000_8000, 32'h0000_8000, 32'h0000_4000, 1'b0);
    push_default(32'h0001_C000, 1'b0);
    bus.in_valid = 1'b1;
    tick();
    set_default(32'hFFFF_0000, 32'h0003_0000, 32'h0001_0000, 32'hFFFF_0000, 32'h0000_0000, 1'b1);
    wait_done_default("bp_a", 18);
    compare_default("bp_a");
    snap = bus.out;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("bp_hold_valid%0d", k), 64'(bus.out_valid), 64'd1);
      check($sformatf("bp_hold_ready%0d", k), 64'(bus.in_ready), 64'd0);
      check($sformatf("bp_hold_out%0d", k), 64'(bus.out == snap), 64'd1);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("bp_after_hs_ready", 64'(bus.in_ready), 64'd1);
    check("bp_after_hs_busy", 64'(busy), 64'd0);
    tick();
    bus.in_valid = 1'b0;
    check("bp_b_accepted_busy", 64'(busy), 64'd1);
    check("bp_b_accepted_ready", 64'(bus.in_ready), 64'd0);
    push_default(32'hFFFC_0000, 1'b1);
    wait_done_default("bp_b", 18);
    compare_default("bp_b");
    handshake_default("bp_b");

    // Reset mid-run at cycle 7 of RUN
    set_default(32'h0001_0000, 32'h0002_0000, 32'h0000_8000, 32'h0000_8000, 32'h0000_4000, 1'b0);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (7) tick();
    rst_n = 1'b0;
    #1;
    check("mrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("mrst_in_ready", 64'(bus.in_ready), 64'd1);
    check("mrst_busy", 64'(busy), 64'd0);
    check("mrst_out", 64'(|bus.out), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    set_default(32'h0001_0000, 32'h0000_0000, 32'h0001_0000, 32'h0001_0000, 32'h7FFF_0000, 1'b0);
    push_default(32'h8000_0000, 1'b0);
    run_default("post_rst");

    // Parameter corners
    for (int k = 0; k < 3; k++) sweep11(k);
    for (int k = 0; k < 3; k++) sweep43(k);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/decoder_mac_scheduler.md
# decoder_mac_scheduler

Time-multiplexed replacement for the fully parallel decoder layer: computes out[j] = b[j] + sum over i of z[i]*w[j*N_input+i] for all M_output neurons using one shared fixed_point_multiply and one shared fixed_point_add. Operands are captured through a valid/ready handshake, a small FSM walks the (j, i) index space one MAC per cycle, and results are presented on a held valid/ready output. It sits between the encoder/latent stage and the decoder activation stage wherever multiplier count matters more than latency.

## Interface
- N_input, 2, number of latent inputs z (must be >= 1)
- M_output, 9, number of decoder outputs (must be >= 1)
- BITSIZE, 32, word width; data format is the team's signed Q16.16
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  operand bundle valid
- in_ready  output  1  block can accept a bundle (high only in IDLE)
- z  input  N_input*BITSIZE  inputs, z[i] at bits [i*BITSIZE +: BITSIZE]
- w  input  N_input*M_output*BITSIZE  weights, w for (j,i) at [(j*N_input+i)*BITSIZE +: BITSIZE]
- b  input  M_output*BITSIZE  biases, b[j] at [j*BITSIZE +: BITSIZE]
- out_valid  output  1  result bundle valid
- out_ready  input  1  downstream accepts result
- out  output  M_output*BITSIZE  results, out[j] at [j*BITSIZE +: BITSIZE]
- busy  output  1  high in RUN or DONE

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready at an edge: register z, w, b; i<=0, j<=0, acc<=b[0]; go RUN. Input ports are not read again until the next accept.
- RUN: each cycle acc_next = acc + mul(z_reg[i], w_reg[j*N_input+i]).
  - i<N_input-1: acc<=acc_next, i<=i+1.
  - i==N_input-1: out_reg[j]<=acc_next; i<=0; if j<M_output-1 then j<=j+1, acc<=b_reg[j+1]; else go DONE.
- DONE: out_valid=1, out stable. On out_valid&&out_ready: go IDLE. No accept in the same cycle as result handshake.
- Arithmetic: mul = (A*B) full 64-bit signed product, arithmetic right shift 16, low 32 bits kept (truncation toward negative infinity, no saturation). add = two's-complement 32-bit wrap, no saturation. Because add wraps, summation order (bias first) gives the same bits as any other order.
- Counters i, j sized $clog2 of max(2, N_input) / max(2, M_output).
- out_reg slots are overwritten only during RUN; out shows previous results outside DONE (don't-care to consumers, but must not be X after reset).

## Timing
- Reset values: in_ready=1 (state IDLE), out_valid=0, busy=0, out=0, acc/i/j/operand registers=0.
- Accept edge = cycle 0. out_valid rises after exactly N_input*M_output edges (18 for defaults); busy high from edge 0 until result handshake edge.
- in_ready falls the cycle after accept and returns the cycle after the result handshake; minimum bundle-to-bundle period N_input*M_output+2 cycles with out_ready tied high.
- out_ready low in DONE: hold state, out_valid and out indefinitely.
- out_ready high outside DONE: ignored. in_valid outside IDLE: ignored, bundle not consumed.
- rst_n low at any time (including mid-RUN or in DONE): immediately return all outputs to reset values; partial results discarded; first accept possible on the first edge after rst_n deasserts.
- N_input=1 or M_output=1 must work (single-iteration loops).

## Test plan
- Basic: z=[0x00010000,0x00020000], all w=0x00008000, all b=0x00004000 -> after 18 cycles every out[j]=0x0001C000, busy high throughout.
- Signed/per-output: z=[0xFFFF0000,0x00030000], w(j,0)=0x00010000, w(j,1)=0xFFFF0000, b[j]=j<<16 -> out[j]=0xFFFC0000+(j<<16).
- Truncation/wrap: z=[0x00000001,0xFFFFFFFF], w=0x00008000 for all, b=0 -> out=0xFFFFFFFF; separately z=[0x00010000,0], w(j,0)=0x00010000, b=0x7FFF0000 -> out=0x80000000.
- Backpressure: out_ready low 5 cycles in DONE, in_valid held high -> out_valid and out stable, in_ready=0, second bundle accepted only one cycle after the handshake.
- Reset mid-run: drop rst_n at cycle 7 of RUN -> out_valid=0, out=0, in_ready=1 immediately; fresh bundle then completes correctly in 18 cycles.
- Parameter sweep: N_input=1,M_output=1 and N_input=4,M_output=3 with random Q16.16 vectors vs reference model, latency N_input*M_output checked each run.
